// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and helpers for the conv1d tap sequencer.
// Contents: FSM state enum, tap count, and the modular ring-index helper
// used by the history buffer read ports.
package conv_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_EMIT = 2'd3
   } state_e;

   localparam int NUM_TAPS = 4;

   // Index 'back' entries behind 'ptr' in a ring of 'depth' entries.
   // Callers guarantee back < depth, so the sum never goes negative and
   // no power-of-two depth is needed.
   function automatic int ring_idx(input int ptr, input int back, input int depth);
      return (ptr + depth - back) % depth;
   endfunction

endpackage

// File: rtl/tap_ring_buffer.sv
// tap_ring_buffer: history of past input samples with four dilated read ports.
// Ports: clk; wr_en_i/wr_ptr_i/wr_dat_i write one sample; fill_i is the count
// of committed samples; tap_dat_o[k] returns sample t-(3-k)*DILATION or zero.
module tap_ring_buffer
   import conv_seq_pkg::*;
#(
   parameter int W        = 16,
   parameter int IN_D     = 4,
   parameter int DILATION = 1,
   localparam int SW      = IN_D * W,
   localparam int DEPTH   = 3 * DILATION + 1,
   localparam int PW      = $clog2(DEPTH),
   localparam int FW      = $clog2(3 * DILATION + 1)
) (
   input  logic                             clk,
   input  logic                             wr_en_i,
   input  logic [PW-1:0]                    wr_ptr_i,
   input  logic [SW-1:0]                    wr_dat_i,
   input  logic [FW-1:0]                    fill_i,
   output logic [NUM_TAPS-1:0][SW-1:0]      tap_dat_o
);

   // Storage is deliberately never reset; stale entries are hidden by the
   // fill-based masking below.
   logic [SW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_i] <= wr_dat_i;
      end
   end

   // Tap k looks (3-k)*DILATION samples back from the slot holding the
   // current sample. It is zeroed until that many older samples exist.
   always_comb begin
      int idx;
      int back;
      idx       = 0;
      back      = 0;
      tap_dat_o = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         back = (NUM_TAPS - 1 - k) * DILATION;
         idx  = ring_idx(int'(wr_ptr_i), back, DEPTH);
         if (int'(fill_i) >= back) begin
            tap_dat_o[k] = mem_q[PW'(idx)];
         end
      end
   end

endmodule

// File: rtl/conv1d_tap_sequencer.sv
// conv1d_tap_sequencer: per-sample controller for one cached dilated conv1d layer.
// Ports: clk/rst/clear; in_data/in_v/in_ready sample input; tap0..tap3, conv_rst,
// conv_relu to the layer; conv_out/conv_out_v from it; out_data/out_v/out_ready result.
module conv1d_tap_sequencer
   import conv_seq_pkg::*;
#(
   parameter int W          = 16,
   parameter int IN_D       = 4,
   parameter int OUT_D      = 8,
   parameter int DILATION   = 1,
   parameter bit APPLY_RELU = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [IN_D*W-1:0]    in_data,
   input  logic                 in_v,
   output logic                 in_ready,
   output logic [IN_D*W-1:0]    tap0,
   output logic [IN_D*W-1:0]    tap1,
   output logic [IN_D*W-1:0]    tap2,
   output logic [IN_D*W-1:0]    tap3,
   output logic                 conv_rst,
   output logic                 conv_relu,
   input  logic [OUT_D*W-1:0]   conv_out,
   input  logic                 conv_out_v,
   output logic [OUT_D*W-1:0]   out_data,
   output logic                 out_v,
   input  logic                 out_ready
);

   localparam int SW       = IN_D * W;
   localparam int OW       = OUT_D * W;
   localparam int DEPTH    = 3 * DILATION + 1;
   localparam int PW       = $clog2(DEPTH);
   localparam int FILL_MAX = 3 * DILATION;
   localparam int FW       = $clog2(FILL_MAX + 1);

   state_e                        state_q, state_d;
   logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]                 fill_q, fill_d;
   logic [NUM_TAPS-1:0][SW-1:0]   tap_q, tap_d;
   logic [OW-1:0]                 out_data_q, out_data_d;

   logic                          wr_en;
   logic [NUM_TAPS-1:0][SW-1:0]   ring_tap;

   // A flush in the same cycle as the handshake wins: nothing is written.
   assign wr_en = (state_q == ST_IDLE) && in_v && !clear && !rst;

   tap_ring_buffer #(
      .W        (W),
      .IN_D     (IN_D),
      .DILATION (DILATION)
   ) u_ring (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_ptr_i  (wr_ptr_q),
      .wr_dat_i  (in_data),
      .fill_i    (fill_q),
      .tap_dat_o (ring_tap)
   );

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      fill_d     = fill_q;
      tap_d      = tap_q;
      out_data_d = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (in_v) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // The new sample sits at wr_ptr now; latch all four taps so they
            // stay stable for the whole layer run.
            tap_d   = ring_tap;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (conv_out_v) begin
               out_data_d = conv_out;
               state_d    = ST_EMIT;
            end
         end
         ST_EMIT: begin
            // The sample is committed to history only once its result has
            // been taken, so a flush before then leaves no trace of it.
            if (out_ready) begin
               wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
               if (fill_q != FW'(FILL_MAX)) begin
                  fill_d = fill_q + 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear) begin
         state_d  = ST_IDLE;
         wr_ptr_d = '0;
         fill_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         tap_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_q     <= fill_d;
         tap_q      <= tap_d;
         out_data_q <= out_data_d;
      end
   end

   // A flush suppresses out_v and holds the layer in reset immediately, so a
   // result being discarded can never complete a downstream handshake.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_v     = (state_q == ST_EMIT) && !clear;
   assign conv_rst  = (state_q != ST_RUN) || clear;
   assign conv_relu = APPLY_RELU;
   assign tap0      = tap_q[0];
   assign tap1      = tap_q[1];
   assign tap2      = tap_q[2];
   assign tap3      = tap_q[3];
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv1d_tap_sequencer.sv
module tb_conv1d_tap_sequencer;

   localparam int W    = 16;
   localparam int IN_D = 4;
   localparam int OD   = 8;
   localparam int SW   = IN_D * W;
   localparam int OW   = OD * W;
   localparam int LAT  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic [SW-1:0] in_data = '0;
   logic          in_v = 1'b0;
   logic          out_ready = 1'b1;
   logic          stray = 1'b0;

   // Instance 1: DILATION=1
   logic          in_ready1, conv_rst1, conv_relu1, conv_out_v1, out_v1;
   logic [SW-1:0] t1_0, t1_1, t1_2, t1_3;
   logic [OW-1:0] conv_out1, out_data1;
   int            cnt1;
   // Instance 2: DILATION=2
   logic          in_ready2, conv_rst2, conv_relu2, conv_out_v2, out_v2;
   logic [SW-1:0] t2_0, t2_1, t2_2, t2_3;
   logic [OW-1:0] conv_out2, out_data2;
   int            cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv1d_tap_sequencer #(.W(W), .IN_D(IN_D), .OUT_D(OD), .DILATION(1), .APPLY_RELU(1'b1)) u_d1 (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_v(in_v), .in_ready(in_ready1),
      .tap0(t1_0), .tap1(t1_1), .tap2(t1_2), .tap3(t1_3), .conv_rst(conv_rst1), .conv_relu(conv_relu1),
      .conv_out(conv_out1), .conv_out_v(conv_out_v1), .out_data(out_data1), .out_v(out_v1),
      .out_ready(out_ready));

   conv1d_tap_sequencer #(.W(W), .IN_D(IN_D), .OUT_D(OD), .DILATION(2), .APPLY_RELU(1'b1)) u_d2 (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_v(in_v), .in_ready(in_ready2),
      .tap0(t2_0), .tap1(t2_1), .tap2(t2_2), .tap3(t2_3), .conv_rst(conv_rst2), .conv_relu(conv_relu2),
      .conv_out(conv_out2), .conv_out_v(conv_out_v2), .out_data(out_data2), .out_v(out_v2),
      .out_ready(out_ready));

   // Stub layer: result valid LAT cycles after its reset is released; the
   // result is simply {tap3, tap0} so the captured value identifies the taps.
   always @(posedge clk) begin
      if (conv_rst1) cnt1 <= 0; else if (cnt1 < 15) cnt1 <= cnt1 + 1;
      if (conv_rst2) cnt2 <= 0; else if (cnt2 < 15) cnt2 <= cnt2 + 1;
   end
   assign conv_out_v1 = (!conv_rst1 && cnt1 >= LAT) || stray;
   assign conv_out_v2 = (!conv_rst2 && cnt2 >= LAT) || stray;
   assign conv_out1   = {t1_3, t1_0};
   assign conv_out2   = {t2_3, t2_0};

   function automatic logic [SW-1:0] rep(input logic [15:0] v);
      return {4{v}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; in_v = 1'b0; out_ready = 1'b1; stray = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Present one sample; returns in the first RUN cycle (taps valid).
   task automatic feed(input logic [SW-1:0] s);
      int n;
      n = 0;
      while (!in_ready1 && n < 20) begin tick(); n++; end
      if (!in_ready1) begin
         checks++; failures++;
         $display("FAIL feed_timeout in_ready=%b required=1", in_ready1);
      end
      in_data = s; in_v = 1'b1;
      tick();
      in_v = 1'b0;
      tick();
   endtask

   // Take the result with out_ready high; returns back in IDLE.
   task automatic drain(output logic [OW-1:0] o1, output logic [OW-1:0] o2);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (!out_v1 && n < 20) begin tick(); n++; end
      if (!out_v1) begin
         checks++; failures++;
         $display("FAIL drain_timeout out_v=%b required=1", out_v1);
      end
      o1 = out_data1; o2 = out_data2;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_ready1 !== 1'b1 || out_v1 !== 1'b0 || conv_rst1 !== 1'b1 || conv_relu1 !== 1'b1) begin
         failures++;
         $display("FAIL reset_ctrl in_ready=%b out_v=%b conv_rst=%b relu=%b required 1 0 1 1",
                  in_ready1, out_v1, conv_rst1, conv_relu1);
      end
      checks++;
      if ({t1_0, t1_1, t1_2, t1_3, t2_0, t2_1, t2_2, t2_3} !== '0) begin
         failures++;
         $display("FAIL reset_taps d1=%h %h %h %h required all 0", t1_0, t1_1, t1_2, t1_3);
      end
      checks++;
      if (out_data1 !== '0 || out_data2 !== '0 || in_ready2 !== 1'b1 || out_v2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_out out_data=%h in_ready2=%b out_v2=%b required 0 1 0",
                  out_data1, in_ready2, out_v2);
      end
   endtask

   task automatic test_priming();
      logic [OW-1:0] o1, o2;
      do_reset();
      feed(rep(16'h1000));
      checks++;
      if ({t1_0, t1_1, t1_2, t1_3} !== {rep(16'h0), rep(16'h0), rep(16'h0), rep(16'h1000)}) begin
         failures++;
         $display("FAIL prime_first taps=%h %h %h %h required 0 0 0 1000", t1_0, t1_1, t1_2, t1_3);
      end
      drain(o1, o2);
      checks++;
      if (o1 !== {rep(16'h1000), rep(16'h0)}) begin
         failures++;
         $display("FAIL prime_first_out out=%h required=%h", o1, {rep(16'h1000), rep(16'h0)});
      end
      feed(rep(16'h2000));
      drain(o1, o2);
      feed(rep(16'h3000));
      checks++;
      if ({t1_0, t1_1, t1_2, t1_3} !== {rep(16'h0), rep(16'h1000), rep(16'h2000), rep(16'h3000)}) begin
         failures++;
         $display("FAIL prime_third taps=%h %h %h %h required 0 1000 2000 3000", t1_0, t1_1, t1_2, t1_3);
      end
      drain(o1, o2);
   endtask

   task automatic test_wrap();
      logic [OW-1:0] o1, o2;
      logic [15:0]   v;
      do_reset();
      for (int n = 0; n < 10; n++) begin
         v = 16'(n * 16'h0100);
         feed(rep(v));
         if (n == 3) begin
            checks++;
            if ({t2_0, t2_1, t2_2, t2_3} !== {rep(16'h0), rep(16'h0), rep(16'h0100), rep(16'h0300)}) begin
               failures++;
               $display("FAIL wrap_n3_d2 taps=%h %h %h %h required 0 0 0100 0300", t2_0, t2_1, t2_2, t2_3);
            end
         end
         if (n == 9) begin
            checks++;
            if ({t2_0, t2_1, t2_2, t2_3} !== {rep(16'h0300), rep(16'h0500), rep(16'h0700), rep(16'h0900)}) begin
               failures++;
               $display("FAIL wrap_n9_d2 taps=%h %h %h %h required 0300 0500 0700 0900", t2_0, t2_1, t2_2, t2_3);
            end
            checks++;
            if ({t1_0, t1_1, t1_2, t1_3} !== {rep(16'h0600), rep(16'h0700), rep(16'h0800), rep(16'h0900)}) begin
               failures++;
               $display("FAIL wrap_n9_d1 taps=%h %h %h %h required 0600 0700 0800 0900", t1_0, t1_1, t1_2, t1_3);
            end
         end
         drain(o1, o2);
         if (n == 9) begin
            checks++;
            if (o2 !== {rep(16'h0900), rep(16'h0300)}) begin
               failures++;
               $display("FAIL wrap_out_d2 out=%h required=%h", o2, {rep(16'h0900), rep(16'h0300)});
            end
         end
      end
   endtask

   task automatic test_latency_backpressure();
      logic [OW-1:0] held, o1, o2;
      logic          ok;
      do_reset();
      out_ready = 1'b0;
      in_data = rep(16'hABCD); in_v = 1'b1;               // cycle 0
      tick(); in_v = 1'b0;                                 // cycle 1
      checks++;
      if (conv_rst1 !== 1'b1 || in_ready1 !== 1'b0) begin
         failures++;
         $display("FAIL lat_c1 conv_rst=%b in_ready=%b required 1 0", conv_rst1, in_ready1);
      end
      tick();                                              // cycle 2
      checks++;
      if (conv_rst1 !== 1'b0 || t1_3 !== rep(16'hABCD)) begin
         failures++;
         $display("FAIL lat_c2 conv_rst=%b tap3=%h required 0 abcd", conv_rst1, t1_3);
      end
      tick(); tick(); tick();                              // cycle 5
      checks++;
      if (out_v1 !== 1'b0) begin
         failures++;
         $display("FAIL lat_c5 out_v=%b required=0", out_v1);
      end
      tick();                                              // cycle 6
      checks++;
      if (out_v1 !== 1'b1 || out_data1 !== {rep(16'hABCD), rep(16'h0)}) begin
         failures++;
         $display("FAIL lat_c6 out_v=%b out_data=%h required 1 %h", out_v1, out_data1,
                  {rep(16'hABCD), rep(16'h0)});
      end
      held = {rep(16'hABCD), rep(16'h0)};
      for (int i = 0; i < 5; i++) begin                    // cycles 6..10
         ok = (out_v1 === 1'b1) && (in_ready1 === 1'b0) && (out_data1 === held);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL hold_%0d out_v=%b in_ready=%b out_data=%h required 1 0 %h",
                     i, out_v1, in_ready1, out_data1, held);
         end
         tick();
      end
      out_ready = 1'b1;                                    // cycle 11
      tick();                                              // cycle 12
      checks++;
      if (in_ready1 !== 1'b1 || out_v1 !== 1'b0) begin
         failures++;
         $display("FAIL release_c12 in_ready=%b out_v=%b required 1 0", in_ready1, out_v1);
      end
      in_data = rep(16'h1234); in_v = 1'b1;
      tick(); in_v = 1'b0;                                 // cycle 13
      checks++;
      if (in_ready1 !== 1'b0) begin
         failures++;
         $display("FAIL accept_c12 in_ready=%b required=0", in_ready1);
      end
      tick();
      drain(o1, o2);
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      in_data = rep(16'h0042); in_v = 1'b1;                // cycle 0
      tick(); in_v = 1'b0;
      tick(); tick(); tick(); tick(); tick();              // cycle 6
      checks++;
      if (out_v1 !== 1'b1 || in_ready1 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_c6 out_v=%b in_ready=%b required 1 0", out_v1, in_ready1);
      end
      tick();                                              // cycle 7
      checks++;
      if (in_ready1 !== 1'b1 || out_v1 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_c7 in_ready=%b out_v=%b required 1 0", in_ready1, out_v1);
      end
   endtask

   task automatic test_stray_result();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      checks++;
      if (out_v1 !== 1'b0 || in_ready1 !== 1'b1) begin
         failures++;
         $display("FAIL stray out_v=%b in_ready=%b required 0 1", out_v1, in_ready1);
      end
   endtask

   task automatic test_clear_mid_run();
      logic [OW-1:0] o1, o2;
      logic          seen;
      do_reset();
      feed(rep(16'h0A00)); drain(o1, o2);
      feed(rep(16'h0B00)); drain(o1, o2);
      in_data = rep(16'h0C00); in_v = 1'b1;                // cycle 0
      tick(); in_v = 1'b0;                                 // cycle 1
      tick(); tick();                                      // cycle 3
      clear = 1'b1;
      tick(); clear = 1'b0;                                // cycle 4
      checks++;
      if (in_ready1 !== 1'b1 || conv_rst1 !== 1'b1 || out_v1 !== 1'b0) begin
         failures++;
         $display("FAIL clear_run in_ready=%b conv_rst=%b out_v=%b required 1 1 0",
                  in_ready1, conv_rst1, out_v1);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_v1 === 1'b1) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL clear_discard out_v_seen=%b required=0", seen);
      end
      feed(rep(16'h0D00));
      checks++;
      if ({t1_0, t1_1, t1_2, t1_3} !== {rep(16'h0), rep(16'h0), rep(16'h0), rep(16'h0D00)}) begin
         failures++;
         $display("FAIL clear_taps taps=%h %h %h %h required 0 0 0 0d00", t1_0, t1_1, t1_2, t1_3);
      end
      drain(o1, o2);
   endtask

   task automatic test_clear_vs_handshake();
      logic [OW-1:0] o1, o2;
      do_reset();
      feed(rep(16'h0E00)); drain(o1, o2);
      clear = 1'b1; in_v = 1'b1; in_data = rep(16'h0F00);
      tick();
      clear = 1'b0; in_v = 1'b0;
      checks++;
      if (in_ready1 !== 1'b1 || conv_rst1 !== 1'b1) begin
         failures++;
         $display("FAIL clr_hs_state in_ready=%b conv_rst=%b required 1 1", in_ready1, conv_rst1);
      end
      feed(rep(16'h0110));
      checks++;
      if ({t1_0, t1_1, t1_2, t1_3} !== {rep(16'h0), rep(16'h0), rep(16'h0), rep(16'h0110)}) begin
         failures++;
         $display("FAIL clr_hs_fill taps=%h %h %h %h required 0 0 0 0110", t1_0, t1_1, t1_2, t1_3);
      end
      drain(o1, o2);
   endtask

   initial begin
      test_reset();
      test_priming();
      test_wrap();
      test_latency_backpressure();
      test_back_to_back();
      test_stray_result();
      test_clear_mid_run();
      test_clear_vs_handshake();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
